// File: rtl/game_board_nxn_if.sv
// Move handshake between the input front end and the N x N game engine.
// The front end drives the request; the engine answers with ready/ack/err.
interface game_board_nxn_if #(
  parameter int COORD_W = 3
);
  logic               move_valid;
  logic [COORD_W-1:0] move_x;
  logic [COORD_W-1:0] move_y;
  logic               move_ready;
  logic               move_ack;
  logic               move_err;

  modport master (
    output move_valid, move_x, move_y,
    input  move_ready, move_ack, move_err
  );

  modport slave (
    input  move_valid, move_x, move_y,
    output move_ready, move_ack, move_err
  );
endinterface

// File: rtl/game_board_nxn.sv
// N x N two-player board engine: move legality, win-in-a-line and draw.
// Define GAME_SCORE_EN to add saturating per-side win counters.
module game_board_nxn #(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  parameter int COORD_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_game,
  game_board_nxn_if.slave  mv,
  output logic             turn,
  output logic [1:0]       vencedor,
  output logic             game_over,
`ifdef GAME_SCORE_EN
  output logic [7:0]       score_player,
  output logic [7:0]       score_cpu,
`endif
  output logic [2*N*N-1:0] board_flat
);

  localparam int NN   = N * N;
  localparam int IDXW = $clog2(NN);
  localparam int PAD  = 1 << IDXW;
  localparam int CW   = $clog2(NN + 1);

  typedef enum logic [1:0] {
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [COORD_W-1:0] lastX, lastY;
  logic [CW-1:0]      moveCount;
  logic               ack, err;
  logic [1:0]         code;
  logic [PAD-1:0]     ownBits, anyBits;
  logic [IDXW-1:0]    reqIdx;
  logic               inRange, legal, full, win, clearAll;

  assign code = turn ? 2'b10 : 2'b01;

  for (genvar g = 0; g < NN; g++) begin : g_cell
    assign ownBits[g] = board_flat[2*g +: 2] == code;
    assign anyBits[g] = |board_flat[2*g +: 2];
  end

  if (PAD > NN) begin : g_pad
    assign ownBits[PAD-1:NN] = '0;
    assign anyBits[PAD-1:NN] = '0;
  end

  assign inRange = (int'(mv.move_x) < N) &&
                   (int'(mv.move_y) < N);
  assign reqIdx  = IDXW'(int'(mv.move_x) * N +
                         int'(mv.move_y));
  assign legal   = inRange && !anyBits[reqIdx];
  assign full    = moveCount == CW'(NN);

  assign mv.move_ready = state == WAIT;
  assign mv.move_ack   = ack;
  assign mv.move_err   = err;

  assign clearAll = new_game &&
                    (state == WAIT || state == DONE);

  // Walk outwards both ways from the last move, stopping at the first
  // foreign/empty cell or the board edge, in each of the four lines.
  always_comb begin
    int  dx, dy, run, cx, cy;
    logic go, hit;
    win = 1'b0;
    dx  = 0;
    dy  = 0;
    run = 0;
    cx  = 0;
    cy  = 0;
    go  = 1'b0;
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dx  = (d == 0) ? 0 : 1;
      dy  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      run = 0;
      for (int s = -1; s <= 1; s += 2) begin
        go = 1'b1;
        for (int k = 1; k < N; k++) begin
          cx  = int'(lastX) + s * k * dx;
          cy  = int'(lastY) + s * k * dy;
          hit = cx >= 0 && cx < N &&
                cy >= 0 && cy < N &&
                ownBits[IDXW'(cx * N + cy)];
          go  = go && hit;
          if (go) run++;
        end
      end
      if (run + 1 >= WIN_LEN) win = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= WAIT;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      WAIT: begin
        if (new_game)                  stateNext = WAIT;
        else if (mv.move_valid && legal) stateNext = CHECK;
      end
      CHECK: stateNext = (win || full) ? DONE : WAIT;
      DONE:  if (new_game) stateNext = WAIT;
      default: stateNext = WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      board_flat <= '0;
      turn       <= 1'b0;
      vencedor   <= 2'd2;
      game_over  <= 1'b0;
      moveCount  <= '0;
      lastX      <= '0;
      lastY      <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
`ifdef GAME_SCORE_EN
      score_player <= '0;
      score_cpu    <= '0;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (clearAll) begin
        board_flat <= '0;
        turn       <= 1'b0;
        vencedor   <= 2'd2;
        game_over  <= 1'b0;
        moveCount  <= '0;
      end else begin
        unique case (state)
          WAIT: begin
            if (mv.move_valid) begin
              if (legal) begin
                for (int i = 0; i < NN; i++)
                  if (reqIdx == IDXW'(i))
                    board_flat[2*i +: 2] <= code;
                lastX     <= mv.move_x;
                lastY     <= mv.move_y;
                moveCount <= moveCount + CW'(1);
                ack       <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (win) begin
              vencedor  <= {1'b0, turn};
              game_over <= 1'b1;
`ifdef GAME_SCORE_EN
              if (turn) begin
                if (score_cpu != 8'hFF)
                  score_cpu <= score_cpu + 8'd1;
              end else begin
                if (score_player != 8'hFF)
                  score_player <= score_player + 8'd1;
              end
`endif
            end else if (full) begin
              vencedor  <= 2'd3;
              game_over <= 1'b1;
            end else begin
              turn <= ~turn;
            end
          end
          DONE: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_board_nxn.sv
// Scoreboard bench for game_board_nxn: a 3x3 instance and a 5x5
// four-in-a-row instance driven from one sequenced initial block.
module tb_game_board_nxn;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic new_game = 1'b0;

  always #5 clock = ~clock;

  game_board_nxn_if #(.COORD_W(2)) bus3 ();
  game_board_nxn_if #(.COORD_W(3)) bus5 ();

  logic        turn3, turn5, over3, over5;
  logic [1:0]  venc3, venc5;
  logic [17:0] board3;
  logic [49:0] board5;
`ifdef GAME_SCORE_EN
  logic [7:0] sp3, sc3, sp5, sc5;
`endif

  game_board_nxn #(.N(3), .WIN_LEN(3), .COORD_W(2)) dut3 (
    .clock(clock), .reset(reset), .new_game(new_game),
    .mv(bus3),
    .turn(turn3), .vencedor(venc3), .game_over(over3),
`ifdef GAME_SCORE_EN
    .score_player(sp3), .score_cpu(sc3),
`endif
    .board_flat(board3)
  );

  game_board_nxn #(.N(5), .WIN_LEN(4), .COORD_W(3)) dut5 (
    .clock(clock), .reset(reset), .new_game(1'b0),
    .mv(bus5),
    .turn(turn5), .vencedor(venc5), .game_over(over5),
`ifdef GAME_SCORE_EN
    .score_player(sp5), .score_cpu(sc5),
`endif
    .board_flat(board5)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] sb[$];
  int cellM[8][8];
  bit turnM;

  function automatic logic [49:0] flatOf(input int n);
    logic [49:0] f;
    f = '0;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++)
        f[2*(x*n+y) +: 2] = 2'(cellM[x][y]);
    return f;
  endfunction

  task automatic resetModel();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        cellM[x][y] = 0;
    turnM = 1'b0;
  endtask

  // Expected handshake response is queued at drive time and popped
  // when the ack/err pulse is due.
  task automatic doMove(input bit big, input int x,
                        input int y, input bit last);
    int n, t;
    bit legal;
    logic [1:0] obs, exp;
    logic [49:0] fl;
    n = big ? 5 : 3;
    legal = (x < n) && (y < n) && (cellM[x][y] == 0);
    sb.push_back(legal ? 2'b10 : 2'b01);
    t = 0;
    while (!(big ? bus5.move_ready : bus3.move_ready) && t < 8) begin
      @(posedge clock); #1;
      t++;
    end
    if (t == 8) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: got ready=0 want 1 (%0d,%0d)", x, y);
      void'(sb.pop_front());
      return;
    end
    if (big) begin
      bus5.move_valid = 1'b1; bus5.move_x = 3'(x); bus5.move_y = 3'(y);
    end else begin
      bus3.move_valid = 1'b1; bus3.move_x = 2'(x); bus3.move_y = 2'(y);
    end
    @(posedge clock); #1;
    bus3.move_valid = 1'b0;
    bus5.move_valid = 1'b0;
    obs = big ? {bus5.move_ack, bus5.move_err}
              : {bus3.move_ack, bus3.move_err};
    exp = sb.pop_front();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL ack_err (%0d,%0d): got %b want %b", x, y, obs, exp);
    end
    if (legal) begin
      cellM[x][y] = turnM ? 2 : 1;
      @(posedge clock); #1;
      if (!last) turnM = ~turnM;
    end
    fl = big ? board5 : 50'(board3);
    vectors++;
    if (fl !== flatOf(n)) begin
      miscompares++;
      $display("FAIL board (%0d,%0d): got %h want %h", x, y, fl, flatOf(n));
    end
    if (!last) begin
      vectors++;
      if ((big ? turn5 : turn3) !== turnM ||
          (big ? venc5 : venc3) !== 2'd2) begin
        miscompares++;
        $display("FAIL turn_venc (%0d,%0d): got %b/%0d want %b/2", x, y,
                 big ? turn5 : turn3, big ? venc5 : venc3, turnM);
      end
    end
    if (!legal) begin
      vectors++;
      if ((big ? bus5.move_ready : bus3.move_ready) !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_after_err: got 0 want 1");
      end
    end
  endtask

  task automatic pulseNewGame();
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
    resetModel();
  endtask

  task automatic test_reset();
    resetModel();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (venc3 !== 2'd2 || over3 !== 1'b0 || turn3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d/%b/%b want 2/0/0",
               venc3, over3, turn3);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (bus3.move_ready !== 1'b1 || board3 !== '0) begin
      miscompares++;
      $display("FAIL reset_ready_board: got %b/%h want 1/0",
               bus3.move_ready, board3);
    end
    vectors++;
    if (bus3.move_ack !== 1'b0 || bus3.move_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ack_err: got %b%b want 00",
               bus3.move_ack, bus3.move_err);
    end
  endtask

  task automatic test_player_win();
    bit seen;
    doMove(0, 0, 0, 0); doMove(0, 1, 0, 0); doMove(0, 0, 1, 0);
    doMove(0, 1, 1, 0); doMove(0, 0, 2, 1);
    vectors++;
    if (venc3 !== 2'd0 || over3 !== 1'b1 || bus3.move_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL player_win: got %0d/%b/%b want 0/1/0",
               venc3, over3, bus3.move_ready);
    end
    bus3.move_valid = 1'b1; bus3.move_x = 2'd1; bus3.move_y = 2'd2;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (bus3.move_ack || bus3.move_err) seen = 1'b1;
    end
    bus3.move_valid = 1'b0;
    vectors++;
    if (seen !== 1'b0 || board3 !== 18'(flatOf(3))) begin
      miscompares++;
      $display("FAIL done_ignores_move: got resp=%b want 0", seen);
    end
`ifdef GAME_SCORE_EN
    vectors++;
    if (sp3 !== 8'd1) begin
      miscompares++;
      $display("FAIL score_player: got %0d want 1", sp3);
    end
`endif
    pulseNewGame();
    vectors++;
    if (board3 !== '0 || venc3 !== 2'd2 || turn3 !== 1'b0 ||
        over3 !== 1'b0) begin
      miscompares++;
      $display("FAIL new_game_clear: got %h/%0d/%b/%b want 0/2/0/0",
               board3, venc3, turn3, over3);
    end
  endtask

  task automatic test_cpu_win();
    doMove(0, 0, 0, 0); doMove(0, 0, 2, 0); doMove(0, 1, 0, 0);
    doMove(0, 1, 1, 0); doMove(0, 2, 2, 0); doMove(0, 2, 0, 1);
    vectors++;
    if (venc3 !== 2'd1 || over3 !== 1'b1 || turn3 !== 1'b1) begin
      miscompares++;
      $display("FAIL cpu_win: got %0d/%b/%b want 1/1/1",
               venc3, over3, turn3);
    end
`ifdef GAME_SCORE_EN
    vectors++;
    if (sc3 !== 8'd1) begin
      miscompares++;
      $display("FAIL score_cpu: got %0d want 1", sc3);
    end
`endif
    pulseNewGame();
    vectors++;
    if (board3 !== '0) begin
      miscompares++;
      $display("FAIL cpu_new_game: got %h want 0", board3);
    end
`ifdef GAME_SCORE_EN
    vectors++;
    if (sc3 !== 8'd1) begin
      miscompares++;
      $display("FAIL score_kept: got %0d want 1", sc3);
    end
`endif
  endtask

  task automatic test_illegal();
    doMove(0, 0, 0, 0);
    doMove(0, 0, 0, 0);
    doMove(0, 3, 0, 0);
    doMove(0, 1, 3, 0);
    doMove(0, 2, 2, 0);
    pulseNewGame();
  endtask

  task automatic test_draw();
    doMove(0, 0, 0, 0); doMove(0, 0, 1, 0); doMove(0, 0, 2, 0);
    doMove(0, 1, 1, 0); doMove(0, 1, 0, 0); doMove(0, 1, 2, 0);
    doMove(0, 2, 1, 0); doMove(0, 2, 0, 0); doMove(0, 2, 2, 1);
    vectors++;
    if (venc3 !== 2'd3 || over3 !== 1'b1) begin
      miscompares++;
      $display("FAIL draw: got %0d/%b want 3/1", venc3, over3);
    end
`ifdef GAME_SCORE_EN
    vectors++;
    if (sp3 !== 8'd1 || sc3 !== 8'd1) begin
      miscompares++;
      $display("FAIL draw_score: got %0d/%0d want 1/1", sp3, sc3);
    end
`endif
    pulseNewGame();
  endtask

  task automatic test_newgame_priority();
    new_game = 1'b1;
    bus3.move_valid = 1'b1; bus3.move_x = 2'd1; bus3.move_y = 2'd1;
    @(posedge clock); #1;
    new_game = 1'b0;
    bus3.move_valid = 1'b0;
    vectors++;
    if (bus3.move_ack !== 1'b0 || board3 !== '0 ||
        bus3.move_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL newgame_priority: got ack=%b board=%h ready=%b want 0/0/1",
               bus3.move_ack, board3, bus3.move_ready);
    end
  endtask

  task automatic test_reset_in_check();
    bus3.move_valid = 1'b1; bus3.move_x = 2'd1; bus3.move_y = 2'd1;
    @(posedge clock); #1;
    bus3.move_valid = 1'b0;
    vectors++;
    if (bus3.move_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL check_entry_ack: got %b want 1", bus3.move_ack);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (board3 !== '0 || venc3 !== 2'd2 || bus3.move_ack !== 1'b0 ||
        bus3.move_ready !== 1'b1 || turn3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_check: got %h/%0d/%b/%b/%b want 0/2/0/1/0",
               board3, venc3, bus3.move_ack, bus3.move_ready, turn3);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    resetModel();
    vectors++;
    if (board3 !== '0 || over3 !== 1'b0 || bus3.move_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset_release: got %h/%b/%b want 0/0/1",
               board3, over3, bus3.move_ready);
    end
  endtask

  task automatic test_n5_middle();
    resetModel();
    doMove(1, 1, 1, 0); doMove(1, 0, 4, 0); doMove(1, 3, 3, 0);
    doMove(1, 4, 0, 0); doMove(1, 4, 4, 0); doMove(1, 0, 3, 0);
    doMove(1, 2, 2, 1);
    vectors++;
    if (venc5 !== 2'd0 || over5 !== 1'b1 || bus5.move_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL n5_middle_win: got %0d/%b/%b want 0/1/0",
               venc5, over5, bus5.move_ready);
    end
  endtask

  initial begin
    bus3.move_valid = 1'b0; bus3.move_x = '0; bus3.move_y = '0;
    bus5.move_valid = 1'b0; bus5.move_x = '0; bus5.move_y = '0;
    test_reset();
    test_player_win();
    test_cpu_win();
    test_illegal();
    test_draw();
    test_newgame_priority();
    test_reset_in_check();
    test_n5_middle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
